shift_add_mult: RTL



---
 rtl/shift_add_mult.sv | 89 ++++++++
 1 files changed

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier, unsigned or two's-complement per operation.
// Each operation takes WIDTH cycles in CALC, then pulses done_o with product_o.
//
// state | meaning
// IDLE  | waiting for start_i; product_o holds the last result
// CALC  | one add-and-shift step per cycle, WIDTH steps in total
module shift_add_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     mcand_i,
   input  logic [WIDTH-1:0]     mplier_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   product_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, CALC} state_t;

   state_t               state;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH:0]     acc;
   logic                 neg;
   logic [CW-1:0]        count;

   logic [WIDTH-1:0]     mcand_mag;
   logic [WIDTH-1:0]     mplier_mag;
   logic [2*WIDTH:0]     acc_next;
   logic [2*WIDTH-1:0]   prod_mag;
   logic [2*WIDTH-1:0]   prod_final;

   // Negating the most negative value wraps back to 2^(WIDTH-1), which is
   // exactly the magnitude wanted when the bits are read as unsigned.
   always_comb begin
      mcand_mag  = (signed_i && mcand_i[WIDTH-1])  ? -mcand_i  : mcand_i;
      mplier_mag = (signed_i && mplier_i[WIDTH-1]) ? -mplier_i : mplier_i;
      acc_next   = (acc + (acc[0] ? {1'b0, mcand, {WIDTH{1'b0}}} : '0)) >> 1;
      prod_mag   = acc_next[2*WIDTH-1:0];
      prod_final = neg ? -prod_mag : prod_mag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         mcand     <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         count     <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         product_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  mcand  <= mcand_mag;
                  acc    <= {{(WIDTH+1){1'b0}}, mplier_mag};
                  neg    <= signed_i & (mcand_i[WIDTH-1] ^ mplier_i[WIDTH-1]);
                  count  <= '0;
                  busy_o <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next;
               count <= count + CW'(1);
               if (count == LAST) begin
                  product_o <= prod_final;
                  done_o    <= 1'b1;
                  busy_o    <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
